// File: rtl/tx_burst_scheduler_if.sv
// Stream interface for tx_burst_scheduler: the user packet stream (S_*)
// and the data/header/send triple toward the TX interface (TX_*).
// The slave modport is the scheduler's view; the master modport is the
// view of whoever drives the user stream and consumes the TX triple.
interface tx_burst_scheduler_if #(
    parameter int CHAN_W = 8
) ();
    logic [63:0]       S_DATA;
    logic              S_VALID;
    logic              S_SOP;
    logic              S_EOP;
    logic [CHAN_W-1:0] S_CHAN;
    logic              S_READY;
    logic              TX_READY;
    logic [63:0]       TX_DATA;
    logic [1:0]        TX_HEADER;
    logic              TX_SEND;

    modport master (
        output S_DATA, S_VALID, S_SOP, S_EOP, S_CHAN, TX_READY,
        input  S_READY, TX_DATA, TX_HEADER, TX_SEND
    );

    modport slave (
        input  S_DATA, S_VALID, S_SOP, S_EOP, S_CHAN, TX_READY,
        output S_READY, TX_DATA, TX_HEADER, TX_SEND
    );
endinterface

// File: rtl/tx_burst_scheduler.sv
// tx_burst_scheduler: segments user packets into bursts of at most
// BURST_MAX data words, framing each burst with a control word (header
// 2'b10) carrying SOP / EOP / channel, and drives the registered
// data/header/send triple feeding the TX interface register stage.
//
// Optional build macro TX_IDLE_CW_EN: when defined, every IDLE cycle with
// nothing else to send emits an idle control word so the lane stays
// continuously framed; when undefined those cycles send nothing.
module tx_burst_scheduler #(
    parameter int BURST_MAX = 8,
    parameter int CHAN_W    = 8
) (
    input logic                  USER_CLK,
    input logic                  SYSTEM_RESET,
    tx_burst_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               pending_eop_q, pending_eop_d;

    logic signed [63:0] tx_data_p0;
    logic [1:0]         tx_header_p0;
    logic               tx_send_p0;
    logic [63:0]        tx_data_p1;
    logic [1:0]         tx_header_p1;
    logic               tx_send_p1;

    // Build a control word; EOP is always full 8 bytes when flagged, and
    // the channel is zero-extended into bits [39:32].
    function automatic logic [63:0] make_cw(
        input logic              burst,
        input logic              sop,
        input logic              eop,
        input logic [CHAN_W-1:0] chan
    );
        logic [63:0] cw;
        cw                 = '0;
        cw[63]             = 1'b1;
        cw[62]             = burst;
        cw[61]             = sop;
        cw[60:57]          = eop ? 4'b1000 : 4'b0000;
        cw[32 +: CHAN_W]   = chan;
        return cw;
    endfunction

    // The user word is only taken while a burst is open and the lane can move.
    assign bus.S_READY = bus.TX_READY && (state_q == DATA) && !SYSTEM_RESET;

    // Next-state and next-output decision for the burst framer.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        pending_eop_d = pending_eop_q;
        tx_data_p0    = '0;
        tx_header_p0  = '0;
        tx_send_p0    = 1'b0;

        if (bus.TX_READY) begin
            case (state_q)
                IDLE: begin
                    if (bus.S_VALID) begin
                        // Open a burst; a pending EOP from the previous
                        // packet rides on this control word.
                        tx_data_p0    = make_cw(1'b1, bus.S_SOP, pending_eop_q, bus.S_CHAN);
                        tx_header_p0  = HDR_CTRL;
                        tx_send_p0    = 1'b1;
                        pending_eop_d = 1'b0;
                        word_cnt_d    = '0;
                        state_d       = DATA;
                    end else if (pending_eop_q) begin
                        tx_data_p0    = make_cw(1'b0, 1'b0, 1'b1, '0);
                        tx_header_p0  = HDR_CTRL;
                        tx_send_p0    = 1'b1;
                        pending_eop_d = 1'b0;
                    end else begin
`ifdef TX_IDLE_CW_EN
                        tx_data_p0    = make_cw(1'b0, 1'b0, 1'b0, '0);
                        tx_header_p0  = HDR_CTRL;
                        tx_send_p0    = 1'b1;
`else
                        tx_send_p0    = 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (bus.S_VALID) begin
                        tx_data_p0   = bus.S_DATA;
                        tx_header_p0 = HDR_DATA;
                        tx_send_p0   = 1'b1;
                        word_cnt_d   = word_cnt_q + 1'b1;
                        // End of packet takes precedence over burst-full so
                        // the EOP is never lost.
                        if (bus.S_EOP) begin
                            pending_eop_d = 1'b1;
                            state_d       = IDLE;
                        end else if (word_cnt_q == CNT_LAST) begin
                            state_d       = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state: FSM, burst word counter and deferred EOP flag.
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            pending_eop_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            pending_eop_q <= pending_eop_d;
        end
    end

    // Stage p0 -> p1: registered output triple toward the TX interface.
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            tx_data_p1   <= '0;
            tx_header_p1 <= '0;
            tx_send_p1   <= 1'b0;
        end else begin
            tx_data_p1   <= tx_data_p0;
            tx_header_p1 <= tx_header_p0;
            tx_send_p1   <= tx_send_p0;
        end
    end

    assign bus.TX_DATA   = tx_data_p1;
    assign bus.TX_HEADER = tx_header_p1;
    assign bus.TX_SEND   = tx_send_p1;
endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Directed, table-driven bench for tx_burst_scheduler (BURST_MAX=8, CHAN_W=8).
// Each record is one clock: inputs are driven on the falling edge, S_READY
// is checked before the rising edge and the registered TX triple after it.
module tb_tx_burst_scheduler;
    logic clk;
    logic rst;

    tx_burst_scheduler_if #(.CHAN_W(8)) bus ();

    tx_burst_scheduler #(.BURST_MAX(8), .CHAN_W(8)) dut (
        .USER_CLK     (clk),
        .SYSTEM_RESET (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TX_IDLE_CW_EN
    localparam logic        IDLE_SEND = 1'b1;
    localparam logic [1:0]  IDLE_HDR  = 2'b10;
    localparam logic [63:0] IDLE_DATA = 64'h8000_0000_0000_0000;
`else
    localparam logic        IDLE_SEND = 1'b0;
    localparam logic [1:0]  IDLE_HDR  = 2'b00;
    localparam logic [63:0] IDLE_DATA = 64'h0;
`endif

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        vld;
        logic        sop;
        logic        eop;
        logic [7:0]  chan;
        logic [63:0] data;
        logic        e_ready;
        logic        e_send;
        logic [1:0]  e_hdr;
        logic [63:0] e_data;
        logic        chk_all;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    task automatic add(input logic r, input logic rdy, input logic vld,
                       input logic sop, input logic eop, input logic [7:0] chan,
                       input logic [63:0] data, input logic e_ready,
                       input logic e_send, input logic [1:0] e_hdr,
                       input logic [63:0] e_data, input logic chk_all);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.vld = vld; v.sop = sop; v.eop = eop;
        v.chan = chan; v.data = data; v.e_ready = e_ready; v.e_send = e_send;
        v.e_hdr = e_hdr; v.e_data = e_data; v.chk_all = chk_all;
        vecs.push_back(v);
    endtask

    // Burst control word emitted from IDLE while the first word waits.
    task automatic cw(input logic sop, input logic [7:0] chan,
                      input logic [63:0] data, input logic [63:0] exp_cw);
        add(1'b0, 1'b1, 1'b1, sop, 1'b0, chan, data, 1'b0, 1'b1, 2'b10, exp_cw, 1'b1);
    endtask

    // Data word accepted and forwarded.
    task automatic wd(input logic sop, input logic eop, input logic [7:0] chan,
                      input logic [63:0] data);
        add(1'b0, 1'b1, 1'b1, sop, eop, chan, data, 1'b1, 1'b1, 2'b01, data, 1'b1);
    endtask

    task automatic idle_eop();
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0, 1'b0, 1'b1, 2'b10,
            64'h9000_0000_0000_0000, 1'b1);
    endtask

    task automatic idle_none();
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0, 1'b0, IDLE_SEND, IDLE_HDR,
            IDLE_DATA, 1'b1);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [63:0] got, input logic [63:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s vec%0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    initial begin
        logic [63:0] w;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.S_DATA = '0; bus.S_VALID = 1'b0; bus.S_SOP = 1'b0;
        bus.S_EOP = 1'b0; bus.S_CHAN = '0; bus.TX_READY = 1'b0;

        // Reset state.
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0, 1'b0, 1'b0, 2'b00, 64'h0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5, 64'h1, 1'b0, 1'b0, 2'b00, 64'h0, 1'b1);

        // 3-word packet, channel 5.
        cw(1'b1, 8'd5, 64'hD000_0000_0000_0000, 64'hE000_0005_0000_0000);
        wd(1'b1, 1'b0, 8'd5, 64'hD000_0000_0000_0000);
        wd(1'b0, 1'b0, 8'd5, 64'hD000_0000_0000_0001);
        wd(1'b0, 1'b1, 8'd5, 64'hD000_0000_0000_0002);
        idle_eop();
        idle_none();

        // 10-word packet, channel 5: split 8 + 2, with one starved cycle.
        cw(1'b1, 8'd5, 64'hA000_0000_0000_0000, 64'hE000_0005_0000_0000);
        for (int i = 0; i < 8; i++) begin
            w = 64'hA000_0000_0000_0000 + 64'(i);
            wd(i == 0, 1'b0, 8'd5, w);
            if (i == 3)
                add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 64'h0, 1'b1, 1'b0, 2'b00, 64'h0, 1'b0);
        end
        cw(1'b0, 8'd5, 64'hA000_0000_0000_0008, 64'hC000_0005_0000_0000);
        wd(1'b0, 1'b0, 8'd5, 64'hA000_0000_0000_0008);
        wd(1'b0, 1'b1, 8'd5, 64'hA000_0000_0000_0009);
        idle_eop();

        // Back-to-back packets: EOP of A merges into CW of B.
        cw(1'b1, 8'd1, 64'hAA00_0000_0000_0000, 64'hE000_0001_0000_0000);
        wd(1'b1, 1'b0, 8'd1, 64'hAA00_0000_0000_0000);
        wd(1'b0, 1'b1, 8'd1, 64'hAA00_0000_0000_0001);
        cw(1'b1, 8'd2, 64'hBB00_0000_0000_0000, 64'hF000_0002_0000_0000);
        wd(1'b1, 1'b0, 8'd2, 64'hBB00_0000_0000_0000);
        wd(1'b0, 1'b1, 8'd2, 64'hBB00_0000_0000_0001);
        idle_eop();
        idle_none();

        // TX_READY low 3 cycles mid-burst; EOP on word 8 (burst-full too).
        cw(1'b1, 8'd3, 64'hC300_0000_0000_0000, 64'hE000_0003_0000_0000);
        for (int i = 0; i < 8; i++) begin
            w = 64'hC300_0000_0000_0000 + 64'(i);
            if (i == 3)
                for (int k = 0; k < 3; k++)
                    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, w, 1'b0, 1'b0, 2'b00, 64'h0, 1'b0);
            wd(i == 0, i == 7, 8'd3, w);
        end
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 64'h0, 1'b0, 1'b0, 2'b00, 64'h0, 1'b0);
        idle_eop();
        idle_none();

        // Reset after word 2 of 5: partial packet dropped, fresh start.
        cw(1'b1, 8'd4, 64'hE400_0000_0000_0000, 64'hE000_0004_0000_0000);
        wd(1'b1, 1'b0, 8'd4, 64'hE400_0000_0000_0000);
        wd(1'b0, 1'b0, 8'd4, 64'hE400_0000_0000_0001);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4, 64'hE400_0000_0000_0002, 1'b0, 1'b0,
            2'b00, 64'h0, 1'b1);
        cw(1'b1, 8'd6, 64'hF600_0000_0000_0000, 64'hE000_0006_0000_0000);
        wd(1'b1, 1'b1, 8'd6, 64'hF600_0000_0000_0000);
        idle_eop();
        idle_none();
        idle_none();
        idle_none();

        foreach (vecs[i]) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            bus.TX_READY = vecs[i].rdy;
            bus.S_VALID  = vecs[i].vld;
            bus.S_SOP    = vecs[i].sop;
            bus.S_EOP    = vecs[i].eop;
            bus.S_CHAN   = vecs[i].chan;
            bus.S_DATA   = vecs[i].data;
            #1;
            check("s_ready", i, 64'(bus.S_READY), 64'(vecs[i].e_ready));
            @(posedge clk);
            #1;
            n_vec++;
            check("tx_send", i, 64'(bus.TX_SEND), 64'(vecs[i].e_send));
            if (vecs[i].chk_all || vecs[i].e_send) begin
                check("tx_header", i, 64'(bus.TX_HEADER), 64'(vecs[i].e_hdr));
                check("tx_data", i, bus.TX_DATA, vecs[i].e_data);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
